bakraid_snd_mailbox: RTL and testbench

// 68000-side end of the main-CPU <-> Z80 sound command mailbox. Decodes 68k sound-window cycles and drives

---
 rtl/bakraid_snd_mailbox_if.sv | 20 ++
 rtl/bakraid_snd_mailbox.sv | 169 ++++++++++++++++
 tb/tb_bakraid_snd_mailbox.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bakraid_snd_mailbox_if.sv
// 68000 sound-window bus seen by the Z80 command mailbox.
// The 68k side drives the strobe, address and write data; the mailbox answers.
interface bakraid_snd_mailbox_if;
    logic       M68K_CS;
    logic       M68K_RNW;
    logic [2:0] M68K_ADDR;
    logic [7:0] M68K_DIN;
    logic [7:0] M68K_DOUT;
    logic       M68K_DTACK_N;

    modport master (
        output M68K_CS, M68K_RNW, M68K_ADDR, M68K_DIN,
        input  M68K_DOUT, M68K_DTACK_N
    );

    modport slave (
        input  M68K_CS, M68K_RNW, M68K_ADDR, M68K_DIN,
        output M68K_DOUT, M68K_DTACK_N
    );
endinterface

// File: rtl/bakraid_snd_mailbox.sv
// 68k-side end of the main CPU <-> Z80 sound mailbox: latches, strobe,
// NMI, reply readback and the DTACK hold that waits for the sound-side ack.
module bakraid_snd_mailbox #(
    parameter int ACK_TIMEOUT = 65535,
    parameter int NMI_W       = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    bakraid_snd_mailbox_if.slave bus,
    output logic [7:0] SOUNDLATCH,
    output logic [7:0] SOUNDLATCH2,
    output logic       SND_CS,
    output logic       SND_NMI,
    input  logic [7:0] SOUNDLATCH3,
    input  logic [7:0] SOUNDLATCH4,
    input  logic [1:0] SOUNDLATCH_ACK,
    output logic [1:0] ACK_RETURN,
    input  logic       SND_WAIT,
    input  logic       SNDIRQ,
    output logic       SND_INT,
    output logic       TIMEOUT_ERR
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int NW = $clog2(NMI_W + 1);

    typedef enum logic [1:0] {IDLE, DECODE, WAIT_ACK, ACK} state_t;

    state_t        state_q;
    logic          cs_q;
    logic [TW-1:0] wcnt_q;
    logic [NW-1:0] ncnt_q;
    logic [7:0]    dout_q;
    logic [7:0]    sl_q;
    logic [7:0]    sl2_q;
    logic          dtack_n_q;
    logic          snd_cs_q;
    logic          nmi_q;
    logic          int_q;
    logic          to_q;
    logic [1:0]    ackret_q;
    logic [1:0]    ackret_d;

    logic       dec;
    logic       rd;
    logic       wr;
    logic       hs_go;
    logic       nmi_go;
    logic       clr_go;
    logic       ack_ok;
    logic       tmo;
    logic [7:0] rdata;

    always_comb begin
        dec    = (state_q == DECODE);
        rd     = dec && bus.M68K_RNW;
        wr     = dec && !bus.M68K_RNW;
        hs_go  = wr && (bus.M68K_ADDR == 3'd2);
        nmi_go = wr && (bus.M68K_ADDR == 3'd2 || bus.M68K_ADDR == 3'd4);
        clr_go = wr && (bus.M68K_ADDR == 3'd5);
        // first two WAIT_ACK cycles (count 1,2) give the sound side time to resync
        ack_ok = (state_q == WAIT_ACK) && (wcnt_q > TW'(2))
               && (|SOUNDLATCH_ACK);
        tmo    = (state_q == WAIT_ACK) && !ack_ok
               && (wcnt_q == TW'(ACK_TIMEOUT));

        ackret_d = SOUNDLATCH_ACK;
        unique case (1'b1)
            hs_go:                              ackret_d = 2'b00;
            rd && (bus.M68K_ADDR == 3'd0):      ackret_d[0] = 1'b0;
            rd && (bus.M68K_ADDR == 3'd1):      ackret_d[1] = 1'b0;
            default: ;
        endcase

        rdata = 8'hFF;
        unique case (bus.M68K_ADDR)
            3'd0:    rdata = SOUNDLATCH3;
            3'd1:    rdata = SOUNDLATCH4;
            3'd4:    rdata = {3'b000, to_q, int_q, SND_WAIT, ackret_q};
            default: rdata = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            cs_q      <= 1'b0;
            wcnt_q    <= '0;
            ncnt_q    <= '0;
            dout_q    <= 8'hFF;
            sl_q      <= 8'h00;
            sl2_q     <= 8'h00;
            dtack_n_q <= 1'b1;
            snd_cs_q  <= 1'b0;
            nmi_q     <= 1'b0;
            int_q     <= 1'b0;
            to_q      <= 1'b0;
            ackret_q  <= 2'b00;
        end else begin
            cs_q     <= bus.M68K_CS;
            ackret_q <= ackret_d;

            if (nmi_q) begin
                if (ncnt_q == NW'(1)) nmi_q <= 1'b0;
                else                  ncnt_q <= ncnt_q - NW'(1);
            end
            // retrigger reloads the width without dropping the line
            if (nmi_go) begin
                nmi_q  <= 1'b1;
                ncnt_q <= NW'(NMI_W);
            end

            if (SNDIRQ)      int_q <= 1'b1;
            else if (clr_go) int_q <= 1'b0;
            if (clr_go) to_q <= 1'b0;
            if (tmo)    to_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (bus.M68K_CS && !cs_q) state_q <= DECODE;
                end
                DECODE: begin
                    if (bus.M68K_RNW) dout_q <= rdata;
                    if (wr && bus.M68K_ADDR == 3'd3) sl2_q <= bus.M68K_DIN;
                    if (hs_go) begin
                        sl_q     <= bus.M68K_DIN;
                        snd_cs_q <= 1'b1;
                        wcnt_q   <= TW'(1);
                        state_q  <= WAIT_ACK;
                    end else if (bus.M68K_CS) begin
                        dtack_n_q <= 1'b0;
                        state_q   <= ACK;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (ack_ok || tmo) begin
                        snd_cs_q <= 1'b0;
                        if (bus.M68K_CS) begin
                            dtack_n_q <= 1'b0;
                            state_q   <= ACK;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                ACK: begin
                    if (!bus.M68K_CS) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.M68K_DOUT    = dout_q;
    assign bus.M68K_DTACK_N = dtack_n_q;
    assign SOUNDLATCH       = sl_q;
    assign SOUNDLATCH2      = sl2_q;
    assign SND_CS           = snd_cs_q;
    assign SND_NMI          = nmi_q;
    assign ACK_RETURN       = ackret_q;
    assign SND_INT          = int_q;
    assign TIMEOUT_ERR      = to_q;
endmodule

// File: tb/tb_bakraid_snd_mailbox.sv
// Bench for the 68k sound mailbox: transaction-level expectations plus
// a per-cycle comparison of every output against the bench's model state.
module tb_bakraid_snd_mailbox;
    localparam int ACK_TIMEOUT = 65535;
    localparam int NMI_W       = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] SOUNDLATCH, SOUNDLATCH2, sl3, sl4;
    logic       SND_CS, SND_NMI, SND_INT, TIMEOUT_ERR;
    logic [1:0] sl_ack, ACK_RETURN;
    logic       snd_wait, sndirq;

    bakraid_snd_mailbox_if bus();

    bakraid_snd_mailbox #(.ACK_TIMEOUT(ACK_TIMEOUT), .NMI_W(NMI_W)) dut (
        .CLK(clk), .RESET_N(rst_n), .bus(bus),
        .SOUNDLATCH(SOUNDLATCH), .SOUNDLATCH2(SOUNDLATCH2),
        .SND_CS(SND_CS), .SND_NMI(SND_NMI),
        .SOUNDLATCH3(sl3), .SOUNDLATCH4(sl4),
        .SOUNDLATCH_ACK(sl_ack), .ACK_RETURN(ACK_RETURN),
        .SND_WAIT(snd_wait), .SNDIRQ(sndirq),
        .SND_INT(SND_INT), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;
    bit irq_en  = 0;
    bit irq_edge;

    // model state, describing what each output must be this cycle
    logic [7:0] m_sl, m_sl2, m_dout;
    logic       m_cs, m_int, m_to, m_dtack_n;
    logic [1:0] m_ackret;
    int         nmi_end;

    // results captured by the driver during the last access
    int         dt_t, nmi_cnt;
    logic [7:0] dt_dout;
    logic [1:0] dt_ackret;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        irq_edge = sndirq;
        if (!rst_n) begin
            m_sl = 8'h00; m_sl2 = 8'h00; m_dout = 8'hFF;
            m_cs = 0; m_int = 0; m_to = 0; m_dtack_n = 1;
            m_ackret = 2'b00; nmi_end = 0;
        end else begin
            m_ackret = sl_ack;
            if (sndirq) m_int = 1;
        end
    end

    always @(posedge clk) begin
        #2;
        sndirq = irq_en && ($urandom_range(0, 15) == 0);
    end

    always @(negedge clk) begin
        if (chk_en && n_fail < 40) begin
            chk("dtack_n", 32'(bus.M68K_DTACK_N), 32'(m_dtack_n));
            chk("dout", 32'(bus.M68K_DOUT), 32'(m_dout));
            chk("soundlatch", 32'(SOUNDLATCH), 32'(m_sl));
            chk("soundlatch2", 32'(SOUNDLATCH2), 32'(m_sl2));
            chk("snd_cs", 32'(SND_CS), 32'(m_cs));
            chk("snd_nmi", 32'(SND_NMI), 32'(cyc < nmi_end));
            chk("ack_return", 32'(ACK_RETURN), 32'(m_ackret));
            chk("snd_int", 32'(SND_INT), 32'(m_int));
            chk("timeout_err", 32'(TIMEOUT_ERR), 32'(m_to));
        end
    end

    // One 68k bus cycle. The sound side shows 'pre' on the ack lines, then
    // 'post' from cycle 'aoff' on. t counts cycles after the CS rise.
    task automatic access(input bit rnw, input bit [2:0] a,
                          input bit [7:0] d, input bit [1:0] pre,
                          input bit [1:0] post, input int aoff,
                          input int hold, input bit drop);
        bit         hs, to_hit;
        int         t_exit, t_dt, t_end;
        logic [7:0] status;
        hs = !rnw && a == 3'd2;
        to_hit = 0;
        t_exit = 0;
        if (hs) begin
            // ack counts from the third WAIT_ACK cycle (t=4) on
            for (int c = 4; c <= 2 + ACK_TIMEOUT - 1; c++)
                if (((c < aoff) ? pre : post) != 2'b00) begin
                    t_exit = c + 1;
                    break;
                end
            if (t_exit == 0) begin
                t_exit = 2 + ACK_TIMEOUT;
                to_hit = 1;
            end
        end
        t_dt  = hs ? t_exit : 2;
        t_end = drop ? t_dt : t_dt + hold + 1;
        dt_t = -1; nmi_cnt = 0; status = 8'h00;
        dt_dout = 8'h00; dt_ackret = 2'b00;

        @(posedge clk); #1;
        bus.M68K_CS = 1; bus.M68K_RNW = rnw;
        bus.M68K_ADDR = a; bus.M68K_DIN = d;
        sl_ack = (aoff > 0) ? pre : post;
        @(negedge clk);
        for (int t = 1; t <= t_end; t++) begin
            @(posedge clk); #1;
            if (t == 1) status = {3'b000, m_to, m_int, snd_wait, m_ackret};
            if (t == 2) begin
                if (rnw) begin
                    case (a)
                        3'd0: m_dout = sl3;
                        3'd1: m_dout = sl4;
                        3'd4: m_dout = status;
                        default: m_dout = 8'hFF;
                    endcase
                    if (a == 3'd0) m_ackret[0] = 1'b0;
                    if (a == 3'd1) m_ackret[1] = 1'b0;
                end else begin
                    if (a == 3'd2) begin
                        m_sl = d; m_cs = 1; m_ackret = 2'b00;
                    end
                    if (a == 3'd3) m_sl2 = d;
                    if (a == 3'd2 || a == 3'd4) nmi_end = cyc + NMI_W;
                    if (a == 3'd5) begin m_int = irq_edge; m_to = 0; end
                end
            end
            if (hs && t == t_exit) begin
                m_cs = 0;
                if (to_hit) m_to = 1;
            end
            if (!drop && t == t_dt) m_dtack_n = 0;
            if (!drop && t == t_dt + hold) bus.M68K_CS = 0;
            if (!drop && t == t_dt + hold + 1) m_dtack_n = 1;
            if (drop && t == (hs ? 3 : 1)) bus.M68K_CS = 0;
            sl_ack = (t < aoff) ? pre : post;
            @(negedge clk);
            if (bus.M68K_DTACK_N === 1'b0 && dt_t < 0) begin
                dt_t = t; dt_dout = bus.M68K_DOUT; dt_ackret = ACK_RETURN;
            end
            if (SND_NMI === 1'b1) nmi_cnt++;
        end
    endtask

    initial begin
        bus.M68K_CS = 0; bus.M68K_RNW = 1;
        bus.M68K_ADDR = 3'd0; bus.M68K_DIN = 8'h00;
        sl3 = 8'h00; sl4 = 8'h00; sl_ack = 2'b00;
        snd_wait = 0; sndirq = 0; rst_n = 0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_dtack_n", 32'(bus.M68K_DTACK_N), 32'd1);
        chk("rst_dout", 32'(bus.M68K_DOUT), 32'hFF);
        chk("rst_snd_cs", 32'(SND_CS), 32'd0);
        chk("rst_soundlatch", 32'(SOUNDLATCH), 32'h00);
        chk("rst_ack_return", 32'(ACK_RETURN), 32'd0);

        access(0, 3'd2, 8'h5A, 2'b00, 2'b01, 10, 0, 0);
        chk("hs_latch", 32'(SOUNDLATCH), 32'h5A);
        chk("hs_dtack_cycle", dt_t, 11);
        chk("hs_nmi_width", nmi_cnt, 4);
        chk("hs_snd_cs_low", 32'(SND_CS), 32'd0);

        sl3 = 8'hC3;
        access(1, 3'd0, 8'h00, 2'b11, 2'b11, 0, 0, 0);
        chk("rd0_dout", 32'(dt_dout), 32'hC3);
        chk("rd0_dtack_cycle", dt_t, 2);
        chk("rd0_ack_return", 32'(dt_ackret), 32'h2);

        access(0, 3'd2, 8'h11, 2'b01, 2'b01, 0, 1, 0);
        chk("held_ack_dtack_cycle", dt_t, 5);

        access(0, 3'd3, 8'h3C, 2'b00, 2'b00, 0, 0, 0);
        chk("latch2", 32'(SOUNDLATCH2), 32'h3C);

        access(0, 3'd2, 8'hA5, 2'b00, 2'b00, 0, 0, 0);
        chk("to_dtack_cycle", dt_t, 2 + ACK_TIMEOUT);
        chk("to_flag", 32'(TIMEOUT_ERR), 32'd1);
        snd_wait = 1;
        access(1, 3'd4, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        chk("status_rd", 32'(dt_dout), 32'h14);
        snd_wait = 0;
        access(0, 3'd5, 8'hFF, 2'b00, 2'b00, 0, 0, 0);
        chk("to_clear", 32'(TIMEOUT_ERR), 32'd0);

        // reset in the middle of a handshake
        @(posedge clk); #1;
        bus.M68K_CS = 1; bus.M68K_RNW = 0;
        bus.M68K_ADDR = 3'd2; bus.M68K_DIN = 8'h77; sl_ack = 2'b00;
        repeat (2) @(posedge clk);
        #1 m_sl = 8'h77; m_cs = 1; m_ackret = 2'b00; nmi_end = cyc + NMI_W;
        @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1; bus.M68K_CS = 0;
        @(negedge clk);
        chk("rst_mid_snd_cs", 32'(SND_CS), 32'd0);
        chk("rst_mid_dtack_n", 32'(bus.M68K_DTACK_N), 32'd1);
        access(1, 3'd6, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        chk("rd6_dout", 32'(dt_dout), 32'hFF);
        chk("rd6_dtack_cycle", dt_t, 2);

        irq_en = 1;
        for (int i = 0; i < 300; i++) begin
            bit rnw, drop;
            bit [2:0] a;
            bit [1:0] pre, post;
            rnw = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            drop = ($urandom_range(0, 9) == 0);
            sl3 = 8'($urandom); sl4 = 8'($urandom);
            snd_wait = 1'($urandom_range(0, 1));
            if (!rnw && a == 3'd2) begin
                pre = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                post = 2'($urandom_range(1, 3));
            end else begin
                pre = 2'($urandom_range(0, 3));
                post = pre;
            end
            access(rnw, a, 8'($urandom), pre, post,
                   $urandom_range(0, 12), $urandom_range(0, 2), drop);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        irq_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
